// File: rtl/divisor_if.sv
// Divider handshake and data bundle.
// Start/finish handshake: the master raises St with the operands. St is
// accepted only on a rising edge where Idle is high, and the operands are
// latched on that edge. Done pulses high for one cycle when Quociente, Resto
// and V are valid. St seen while Idle is low is dropped, not queued.
interface divisor_if #(
    parameter int N = 16
);
    logic             St;
    logic [2*N-1:0]   Dividendo;
    logic [N-1:0]     Divisor;
    logic             Done;
    logic             Idle;
    logic [N-1:0]     Quociente;
    logic [N-1:0]     Resto;
    logic             V;

    modport master (
        output St, Dividendo, Divisor,
        input  Done, Idle, Quociente, Resto, V
    );

    modport slave (
        input  St, Dividendo, Divisor,
        output Done, Idle, Quociente, Resto, V
    );
endinterface

// File: rtl/divisor.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor.
// It produces one quotient bit per cycle. A quotient that would not fit in
// N bits, or a zero divisor, is caught in one CHECK cycle and reported
// through V.
module divisor #(
    parameter int N = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    divisor_if.slave   bus,
    output logic [1:0] o_dbg_state
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    // A is held in N bits: between iterations it is always below D, so its
    // top bit is zero. The only N+1-bit value is the shifted A below.
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_d;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_quo;
    logic [N-1:0]    r_rem;
    logic            r_v;
    logic            r_done;
    logic            r_idle;

    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N-1:0]    w_a_next;
    logic [N-1:0]    w_q_next;

    // One restoring step: shift {A,Q} left, then subtract D when it fits.
    // The difference is below D, so N-bit modular subtraction gives it exactly.
    always_comb begin
        w_shift  = {r_a, r_q[N-1]};
        w_ge     = (w_shift >= {1'b0, r_d});
        w_a_next = w_ge ? (w_shift[N-1:0] - r_d) : w_shift[N-1:0];
        w_q_next = {r_q[N-2:0], w_ge};
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.St) begin
                        r_d     <= bus.Divisor;
                        r_a     <= bus.Dividendo[2*N-1:N];
                        r_q     <= bus.Dividendo[N-1:0];
                        r_cnt   <= '0;
                        r_idle  <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A high half >= D means the quotient needs more than N
                    // bits. D = 0 always lands here as well.
                    if (r_a >= r_d) begin
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_v     <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_quo   <= w_q_next;
                        r_rem   <= w_a_next;
                        r_v     <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Done      = r_done;
    assign bus.Idle      = r_idle;
    assign bus.Quociente = r_quo;
    assign bus.Resto     = r_rem;
    assign bus.V         = r_v;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_divisor.sv
// Testbench for divisor: directed cases plus random divisions, checked by a
// scoreboard against a plain arithmetic reference.
module tb_divisor;
    localparam int N = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    divisor_if #(.N(N)) bus ();
    logic [1:0] dbg_state;

    divisor #(.N(N)) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [2*N:0] exp_q[$];     // {V, quotient, remainder}
    int           exp_cyc_q[$]; // edge count at which Done must be seen
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: ordinary integer division, with the overflow rule that the
    // quotient must fit in N bits and the divisor must be nonzero.
    function automatic logic [2*N:0] model(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        longint unsigned a, b, q, r;
        logic [N-1:0] qq, rr;
        a = longint'(dd);
        b = longint'(dv);
        if (b == 0) return {1'b1, {(2*N){1'b0}}};
        q = a / b;
        r = a % b;
        if (q > 64'((1 << N) - 1)) return {1'b1, {(2*N){1'b0}}};
        qq = q[N-1:0];
        rr = r[N-1:0];
        return {1'b0, qq, rr};
    endfunction

    // Monitor: pops and compares whenever the DUT presents Done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) begin
                check("idle_after_done", 64'(bus.Idle), 64'd1);
                check("done_one_cycle", 64'(bus.Done), 64'd0);
            end
            if (bus.Done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 expected none (cycle %0d)", cyc);
                end else begin
                    check("result", 64'({bus.V, bus.Quociente, bus.Resto}), 64'(exp_q.pop_front()));
                    check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                    check("idle_low_with_done", 64'(bus.Idle), 64'd0);
                end
            end
        end
        prev_done <= bus.Done;
    end

    // ---------------- driver ----------------
    task automatic start_div(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input bit keep_st);
        int n;
        logic [2*N:0] e;
        n = 0;
        @(negedge clk);
        while (!bus.Idle && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Idle) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got Idle=0 expected 1 within 200 cycles");
            return;
        end
        bus.Dividendo = dd;
        bus.Divisor   = dv;
        bus.St        = 1'b1;
        e = model(dd, dv);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1 + (e[2*N] ? 1 : N + 1));
        @(posedge clk);
        #1;
        // Operands are scrambled after the start edge; they must be ignored.
        bus.Dividendo = $urandom;
        bus.Divisor   = N'($urandom);
        if (!keep_st) bus.St = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned q, r, dv;
        logic [2*N-1:0] dd;
        bit keep;

        bus.St        = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset_idle", 64'(bus.Idle), 64'd1);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_quo", 64'(bus.Quociente), 64'd0);
        check("reset_rem", 64'(bus.Resto), 64'd0);
        check("reset_v", 64'(bus.V), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // single run
        start_div(32'd15, 16'd5, 1'b0);
        drain();

        // back-to-back with St held high
        start_div(32'd49, 16'd7, 1'b1);
        start_div(32'd36, 16'd3, 1'b1);
        start_div(32'd100, 16'd7, 1'b0);
        drain();

        // overflow and boundary cases
        start_div(32'd1234, 16'd0, 1'b0);
        start_div(32'h0005_0000, 16'd5, 1'b0);
        start_div(32'h0004_FFFF, 16'd5, 1'b0);
        start_div(32'hFFFE_0001, 16'hFFFF, 1'b0);
        drain();

        // reset in the middle of a run
        start_div(32'd100, 16'd7, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_quo", 64'(bus.Quociente), 64'd0);
        check("abort_rem", 64'(bus.Resto), 64'd0);
        check("abort_v", 64'(bus.V), 64'd0);
        check("abort_idle", 64'(bus.Idle), 64'd1);
        check("abort_done", 64'(bus.Done), 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("post_abort_quo", 64'(bus.Quociente), 64'd0);
        start_div(32'd100, 16'd7, 1'b0);
        drain();

        // random divisions, mixed single and back-to-back
        for (int i = 0; i < 40; i++) begin
            dv = (i % 10 == 9) ? 0 : $urandom_range(1, 65535);
            if ($urandom_range(0, 3) == 0 || dv == 0) begin
                dd = $urandom;
            end else begin
                q  = $urandom_range(0, 65535);
                r  = $urandom_range(0, dv - 1);
                dd = q * dv + r;
            end
            keep = (i != 39) && ($urandom_range(0, 1) == 1);
            start_div(dd, N'(dv), keep);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/divisor.md
# divisor

Sequential restoring divider, the inverse of the shift-add multiplier in the MIPS datapath. It divides a 2N-bit dividend by an N-bit divisor and returns an N-bit quotient and an N-bit remainder. Quotient overflow and divide-by-zero are flagged. It uses the same St/Done/Idle handshake as the multiplier, so the control unit drives both units identically.

## Interface
- N, 16, operand width; dividend is 2N bits, divisor, quotient and remainder are N bits
- Clk  input  1  clock; all state changes on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- St  input  1  start request; sampled only in IDLE
- Dividendo  input  2N  dividend; latched on accepted start
- Divisor  input  N  divisor; latched on accepted start
- Done  output  1  high for exactly one cycle (DONE state); results valid
- Idle  output  1  high in IDLE only
- Quociente  output  N  quotient, registered
- Resto  output  N  remainder, registered
- V  output  1  overflow/divide-by-zero flag, registered

## Operation
- States: IDLE, CHECK, ITER, DONE.
- IDLE with St=1 at a rising edge:
  - latch Divisor into D;
  - A (N+1 bits) = {0, Dividendo[2N-1:N]}, Q = Dividendo[N-1:0];
  - iteration counter = 0;
  - go to CHECK.
- IDLE with St=0: stay in IDLE.
- CHECK:
  - if A[N-1:0] >= D (this also covers D=0): Quociente=0, Resto=0, V=1, go to DONE;
  - otherwise go to ITER.
- ITER, one quotient bit per cycle:
  - shift {A,Q} left by 1;
  - if the shifted A >= {0,D}: A = shifted A − D and Q[0]=1, else Q[0]=0;
  - counter increments each cycle;
  - after N iterations go to DONE, loading Quociente=Q, Resto=A[N-1:0], V=0.
- Width rule: entering ITER guarantees A < D, so the shifted A < 2D and fits in N+1 bits; the subtraction never underflows.
- DONE always goes to IDLE at the next edge.
  - If St is still high, a new division starts on the following edge.
  - Holding St high therefore gives back-to-back runs.
- Quociente, Resto and V change only on entry to DONE (or on reset). They hold between runs.
- Operand inputs are ignored outside the start edge.

## Timing
- Reset (asynchronous, Rst_n=0):
  - state IDLE, Idle=1, Done=0, Quociente=0, Resto=0, V=0;
  - A, Q, D and the counter are cleared.
- Reset mid-operation aborts the division; no Done is produced and the outputs read 0.
- Edge 0 is the edge where St=1 is sampled in IDLE. Idle falls after edge 0.
- Normal run:
  - CHECK after edge 0;
  - ITER occupies edges 1..N;
  - DONE is entered at edge N+1;
  - Done=1 from edge N+1 to edge N+2 (N=16: Done rises 17 edges after the start);
  - Idle returns at edge N+2.
- Overflow/zero run: DONE is entered at edge 1; Done=1 from edge 1 to edge 2.
- Done and Idle are never high together. Done is never high for more than one cycle per accepted start.
- Results are stable when Done rises and stay stable until the next DONE entry.
- St pulses outside IDLE are ignored; they are not queued.

## Test plan
- Dividendo=15, Divisor=5, single St pulse → Done high once after 17 edges; Quociente=3, Resto=0, V=0; Idle=1 one cycle later.
- St held high; operand pairs 49/7, 36/3, 100/7 applied in turn → consecutive results 7 r0, 12 r0, 14 r2. Each Done is one cycle wide and each restart occurs one edge after Idle rises.
- Divisor=0, Dividendo=1234 → V=1, Quociente=0, Resto=0, with Done after edge 1 (2-cycle latency).
- Dividendo=0x0005_0000, Divisor=5 (quotient needs 17 bits) → V=1, 2-cycle latency. Dividendo=0x0004_FFFF, Divisor=5 → V=0, Quociente=0xFFFF, Resto=4.
- Maximum case Dividendo=0xFFFE_0001, Divisor=0xFFFF → Quociente=0xFFFF, Resto=0, V=0; no N+1-bit overflow in A.
- Rst_n pulsed low at edge 8 of a 100/7 run → outputs go to 0 immediately and Idle=1; no Done. A new 100/7 run afterwards gives 14 r2. Changing the operands mid-run (without reset) does not alter the result.
